// File: rtl/db_fe_ctrl_pkg.sv
// Shared constants for the daughterboard front-end control block:
// settings/readback offsets and the {tx,rx} ATR state encoding.
package db_fe_ctrl_pkg;

   localparam logic [7:0] OFF_ATR_IDLE = 8'd0;
   localparam logic [7:0] OFF_ATR_RX   = 8'd1;
   localparam logic [7:0] OFF_ATR_TX   = 8'd2;
   localparam logic [7:0] OFF_ATR_FDX  = 8'd3;
   localparam logic [7:0] OFF_DDR      = 8'd4;
   localparam logic [7:0] OFF_ATR_DIS  = 8'd5;
   localparam logic [7:0] OFF_CNT_CLR  = 8'd6;

   localparam logic [7:0] RB_OFF_GPIO  = 8'd0;
   localparam logic [7:0] RB_OFF_RXID  = 8'd1;
   localparam logic [7:0] RB_OFF_FDTX  = 8'd2;
   localparam logic [7:0] RB_OFF_DSDR  = 8'd3;
   localparam logic [7:0] RB_OFF_STATE = 8'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RX   = 2'b01,
      ST_TX   = 2'b10,
      ST_FDX  = 2'b11
   } atr_state_e;

endpackage

// File: rtl/db_fe_ctrl_if.sv
// Settings-write and readback bus between the radio block (master) and
// the front-end control block (slave).
interface db_fe_ctrl_if;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [7:0]  rb_addr;
   logic        rb_stb;
   logic [63:0] rb_data;

   modport master (output set_stb, set_addr, set_data, rb_addr,
                   input  rb_stb, rb_data);
   modport slave  (input  set_stb, set_addr, set_data, rb_addr,
                   output rb_stb, rb_data);
endinterface

// File: rtl/db_fe_rb_handshake.sv
// Readback handshake: drops rb_stb for one cycle whenever rb_addr moves and
// reloads rb_data from the combinational mux every cycle.
module db_fe_rb_handshake (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  i_rb_addr,
   input  logic [63:0] i_rb_mux,
   output logic        o_rb_stb,
   output logic [63:0] o_rb_data
);

   logic [7:0]  r_rb_addr;
   logic        r_primed;
   logic        r_rb_stb;
   logic [63:0] r_rb_data;
   logic        w_addr_chg;

   assign w_addr_chg = (i_rb_addr != r_rb_addr);

   // r_primed holds off the first strobe after reset regardless of address
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rb_addr <= '0;
         r_primed  <= 1'b0;
         r_rb_stb  <= 1'b0;
         r_rb_data <= '0;
      end else begin
         r_rb_addr <= i_rb_addr;
         r_primed  <= 1'b1;
         r_rb_stb  <= r_primed && !w_addr_chg;
         r_rb_data <= i_rb_mux;
      end
   end

   assign o_rb_stb  = r_rb_stb;
   assign o_rb_data = r_rb_data;

endmodule

// File: rtl/db_fe_ctrl.sv
// Per-channel front-end control: ATR-driven GPIO, settings registers and readback.
// Optional transition counter enabled by defining DB_FE_ATR_CNT_EN.
module db_fe_ctrl
   import db_fe_ctrl_pkg::*;
#(
   parameter logic [7:0] SR_BASE = 8'd160,
   parameter logic [7:0] RB_BASE = 8'd16,
   parameter int         WIDTH   = 32
) (
   input  logic             clk,
   input  logic             reset,
   db_fe_ctrl_if.slave      fe_bus,
   input  logic             rx_running,
   input  logic             tx_running,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_ddr,
   output logic [1:0]       atr_state
);

   logic [WIDTH-1:0] r_idle, r_rx, r_tx, r_fdx, r_ddr, r_dis;
   logic [WIDTH-1:0] r_gpio_out, r_sync1, r_sync2;
   atr_state_e       r_atr_state;

   logic [7:0]       w_set_off;
   logic [WIDTH-1:0] w_wdata;
   atr_state_e       w_atr_next;
   logic [WIDTH-1:0] w_atr_sel;
   logic [31:0]      w_cnt;
   logic [7:0]       w_rb_off;
   logic [63:0]      w_rb_mux;

   assign w_set_off  = fe_bus.set_addr - SR_BASE;
   assign w_wdata    = fe_bus.set_data[WIDTH-1:0];
   assign w_atr_next = atr_state_e'({tx_running, rx_running});

   always_comb begin
      w_atr_sel = r_fdx;
      case (r_atr_state)
         ST_IDLE: w_atr_sel = r_idle;
         ST_RX:   w_atr_sel = r_rx;
         ST_TX:   w_atr_sel = r_tx;
         default: w_atr_sel = r_fdx;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idle      <= '0;
         r_rx        <= '0;
         r_tx        <= '0;
         r_fdx       <= '0;
         r_ddr       <= '0;
         r_dis       <= '0;
         r_gpio_out  <= '0;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_atr_state <= ST_IDLE;
      end else begin
         r_atr_state <= w_atr_next;
         r_sync1     <= gpio_in;
         r_sync2     <= r_sync1;
         // ATR-disabled bits are pinned to the idle value
         r_gpio_out  <= (r_dis & r_idle) | (~r_dis & w_atr_sel);
         if (fe_bus.set_stb) begin
            case (w_set_off)
               OFF_ATR_IDLE: r_idle <= w_wdata;
               OFF_ATR_RX:   r_rx   <= w_wdata;
               OFF_ATR_TX:   r_tx   <= w_wdata;
               OFF_ATR_FDX:  r_fdx  <= w_wdata;
               OFF_DDR:      r_ddr  <= w_wdata;
               OFF_ATR_DIS:  r_dis  <= w_wdata;
               default: ;
            endcase
         end
      end
   end

`ifdef DB_FE_ATR_CNT_EN
   logic [31:0] r_cnt;

   // a clear coincident with a transition wins
   always_ff @(posedge clk) begin
      if (reset)
         r_cnt <= '0;
      else if (fe_bus.set_stb && (w_set_off == OFF_CNT_CLR))
         r_cnt <= '0;
      else if (w_atr_next != r_atr_state)
         r_cnt <= r_cnt + 32'd1;
   end

   assign w_cnt = r_cnt;
`else
   assign w_cnt = 32'd0;
`endif

   assign w_rb_off = fe_bus.rb_addr - RB_BASE;

   always_comb begin
      w_rb_mux = '0;
      case (w_rb_off)
         RB_OFF_GPIO:  w_rb_mux = {32'd0, 32'(r_sync2)};
         RB_OFF_RXID:  w_rb_mux = {32'(r_rx), 32'(r_idle)};
         RB_OFF_FDTX:  w_rb_mux = {32'(r_fdx), 32'(r_tx)};
         RB_OFF_DSDR:  w_rb_mux = {32'(r_dis), 32'(r_ddr)};
         RB_OFF_STATE: w_rb_mux = {30'd0, r_atr_state, w_cnt};
         default:      w_rb_mux = '0;
      endcase
   end

   db_fe_rb_handshake u_rb (
      .clk       (clk),
      .reset     (reset),
      .i_rb_addr (fe_bus.rb_addr),
      .i_rb_mux  (w_rb_mux),
      .o_rb_stb  (fe_bus.rb_stb),
      .o_rb_data (fe_bus.rb_data)
   );

   assign gpio_out  = r_gpio_out;
   assign gpio_ddr  = r_ddr;
   assign atr_state = r_atr_state;

endmodule

// File: doc/db_fe_ctrl.md
Name: db_fe_ctrl

Overview:
Per-channel daughterboard/front-end control block.
- Consumes the exported timed settings bus (db_fe_set_*) and readback address (db_fe_rb_addr) of the radio NoC block.
- Returns db_fe_rb_stb/db_fe_rb_data to it.
- Drives ATR-controlled front-end GPIO from rx_running/tx_running.
- One instance per channel, in the ce_clk domain.

Parameters:
SR_BASE, 8'd160, first settings address owned by this block (equals SR_DB_FE_BASE).
RB_BASE, 8'd16, first readback address owned by this block (equals RB_DB_FE_BASE).
WIDTH, 32, GPIO width, 1..32.

Ports:
clk  in  1  ce_clk.
reset  in  1  synchronous, active-high.
set_stb  in  1  settings write strobe.
set_addr  in  8  settings address.
set_data  in  32  settings data.
rb_addr  in  8  readback address, held stable by the consumer while waiting.
rb_stb  out  1  rb_data valid for the current rb_addr.
rb_data  out  64  readback data.
rx_running  in  1  RX active.
tx_running  in  1  TX active.
gpio_in  in  WIDTH  asynchronous pin inputs.
gpio_out  out  WIDTH  pin output values.
gpio_ddr  out  WIDTH  1 = output.
atr_state  out  2  {tx,rx} registered state.

Behaviour:
- One clock; reset is synchronous and active-high. clk/reset are ce_clk/ce_rst at the instantiation.
- Reset values: all registers 0, gpio_out 0, gpio_ddr 0, atr_state 0, rb_stb 0, rb_data 0, transition counter 0.
- Write registers, offset from SR_BASE. Only low WIDTH bits are stored; upper data bits are ignored.
  - 0 ATR_IDLE
  - 1 ATR_RX
  - 2 ATR_TX
  - 3 ATR_FDX
  - 4 DDR
  - 5 ATR_DIS: per-bit mask; 1 = bit is static and always follows ATR_IDLE.
  - 6 CNT_CLR: data ignored.
- A write takes effect the cycle after set_stb. Addresses outside SR_BASE..SR_BASE+6 are ignored.
- ATR state machine:
  - atr_state <= {tx_running, rx_running} every cycle.
  - States: IDLE=00, RX=01, TX=10, FDX=11. Every transition is legal, including 00->11 in a single cycle.
- gpio_out (registered):
  - For each bit, ATR_DIS ? ATR_IDLE : reg[atr_state], where reg is selected by the already-registered atr_state.
  - Latency from a running-input change to gpio_out is 2 cycles.
  - A register write changes gpio_out 2 cycles after set_stb.
- gpio_ddr = DDR register.
- Transition counter: 32-bit, increments when atr_state changes, wraps 0xFFFFFFFF->0. CNT_CLR write in the same cycle as a transition: clear wins, result 0.
- gpio_in passes through a 2-flop synchronizer before readback.
- Readback, offset from RB_BASE. Unused high bits are zero-padded.
  - 0: {32'b0, gpio_in_sync}
  - 1: {ATR_RX, ATR_IDLE}
  - 2: {ATR_FDX, ATR_TX}
  - 3: {ATR_DIS, DDR}
  - 4: {30'b0, atr_state, counter}
  - Other addresses: 64'h0.
- Readback handshake:
  - rb_addr is registered every cycle.
  - Cycle N: rb_addr differs from the registered copy. rb_stb deasserts at N+1.
  - N+1: rb_data is loaded from the new address.
  - N+2: rb_stb reasserts.
  - While rb_addr is stable, rb_stb stays 1 and rb_data refreshes every cycle.
  - After reset release: rb_stb asserts on the second cycle, for whatever address is present.
- Reset mid-operation clears everything, including a readback in progress, in the same cycle.

Optional Feature:
DB_FE_ATR_CNT_EN.
- Defined: transition counter, CNT_CLR and readback offset 4 are present as described.
- Undefined: the counter is not synthesized, CNT_CLR writes are ignored, and readback offset 4 returns {30'b0, atr_state, 32'b0}.

Decomposition:
- Package db_fe_ctrl_pkg holds:
  - write offsets (OFF_ATR_IDLE..OFF_CNT_CLR = 0..6);
  - readback offsets (RB_OFF_GPIO..RB_OFF_STATE = 0..4);
  - atr_state encoding constants ST_IDLE/ST_RX/ST_TX/ST_FDX.
- One sub-module, db_fe_rb_handshake: address-change detect, rb_stb holdoff and rb_data register, taking a combinational mux input.

Test Plan:
- Reset, then rb_addr=RB_BASE+3 held -> rb_stb=0 for 1 cycle, then 1, rb_data=0.
- Write ATR_IDLE=0x1, RX=0x2, TX=0x4, FDX=0x8 and DDR=0xF. Step {tx,rx} 00->01->10->11 -> gpio_out 0x1,0x2,0x4,0x8, each 2 cycles after the input change; gpio_ddr=0xF.
- ATR_DIS=0x8 with FDX=0x0 and IDLE=0x8, state FDX -> gpio_out=0x8.
- rb_addr changes RB_BASE+1 -> RB_BASE+2 at cycle N -> rb_stb low at N+1, high at N+2, rb_data={FDX,TX}={0x8,0x4}.
- Drive gpio_in=0xA5 -> RB_BASE+0 reads 0xA5 no earlier than 3 cycles later. Write to SR_BASE+7 -> no register changes.
- DB_FE_ATR_CNT_EN defined: 5 transitions -> count 5. CNT_CLR coincident with a transition -> 0. Undefined: count field reads 0.
